// File: rtl/audio_sample_buffer.sv
// audio_sample_buffer: multi-channel PCM frame FIFO. Frames are captured on a data change or a strobe,
// one frame is released per tick, the last frame is held on underflow, and overflow/underflow are sticky.
module audio_sample_buffer #(
  parameter int DATA_W        = 16,
  parameter int CHANNELS      = 2,
  parameter int DEPTH         = 8,
  parameter int CHANGE_DETECT = 1
) (
  input  logic                         clk_sys,
  input  logic                         reset,
  input  logic [CHANNELS*DATA_W-1:0]   in_data,
  input  logic                         in_valid,
  input  logic                         out_tick,
  output logic [CHANNELS*DATA_W-1:0]   out_data,
  output logic                         out_valid,
  output logic [$clog2(DEPTH):0]       level,
  output logic                         overflow,
  output logic                         underflow,
  input  logic                         clear_flags
);
  localparam int FW = CHANNELS * DATA_W;
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  logic [FW-1:0] r_mem [DEPTH];
  logic [FW-1:0] r_prev, r_rd_q, r_out;
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_level;
  logic          r_pend, r_out_valid, r_ovf, r_unf;
  logic          w_wr_ev, w_full, w_empty, w_pop, w_wr;
  assign w_wr_ev = (CHANGE_DETECT != 0) ? (in_data != r_prev) : in_valid;
  assign w_full  = r_level == FULL_LVL;
  assign w_empty = r_level == '0;
  assign w_pop   = out_tick && !w_empty;
  // A full FIFO still accepts a write when a pop frees a slot on the same edge.
  assign w_wr    = w_wr_ev && (!w_full || w_pop);
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_prev      <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
      r_pend      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
    end else begin
      r_prev      <= in_data;
      r_wr_ptr    <= w_wr ? r_wr_ptr + 1'b1 : r_wr_ptr;
      r_rd_ptr    <= w_pop ? r_rd_ptr + 1'b1 : r_rd_ptr;
      r_level     <= r_level + (AW+1)'(w_wr) - (AW+1)'(w_pop);
      r_pend      <= w_pop;
      r_out_valid <= r_pend;
      r_out       <= r_pend ? r_rd_q : r_out;
      r_ovf       <= (w_wr_ev && w_full && !w_pop) ? 1'b1 : clear_flags ? 1'b0 : r_ovf;
      r_unf       <= (out_tick && w_empty) ? 1'b1 : clear_flags ? 1'b0 : r_unf;
    end
  end
  // Storage and its read register carry no reset so the array maps onto block RAM.
  always_ff @(posedge clk_sys) begin
    if (w_wr) r_mem[r_wr_ptr] <= in_data;
    if (w_pop) r_rd_q <= r_mem[r_rd_ptr];
  end
  assign out_data  = r_out;
  assign out_valid = r_out_valid;
  assign level     = r_level;
  assign overflow  = r_ovf;
  assign underflow = r_unf;
endmodule

// File: tb/tb_audio_sample_buffer.sv
// tb_audio_sample_buffer: directed and randomized checks of both capture modes against a queue-based model.
module tb_audio_sample_buffer;
  logic clk = 0;
  logic reset = 1;
  always #5 clk = ~clk;
  logic [31:0] d1 = 0, d0 = 0;
  logic v1 = 0, v0 = 0, t1 = 0, t0 = 0, c1 = 0, c0 = 0;
  logic [31:0] o1_d, o0_d;
  logic o1_v, o0_v, o1_ovf, o0_ovf, o1_unf, o0_unf;
  logic [3:0] o1_l, o0_l;
  int checks = 0, errors = 0;

  audio_sample_buffer #(.DATA_W(16), .CHANNELS(2), .DEPTH(8), .CHANGE_DETECT(1)) dut1 (
    .clk_sys(clk), .reset(reset), .in_data(d1), .in_valid(v1), .out_tick(t1),
    .out_data(o1_d), .out_valid(o1_v), .level(o1_l), .overflow(o1_ovf),
    .underflow(o1_unf), .clear_flags(c1));
  audio_sample_buffer #(.DATA_W(16), .CHANNELS(2), .DEPTH(8), .CHANGE_DETECT(0)) dut0 (
    .clk_sys(clk), .reset(reset), .in_data(d0), .in_valid(v0), .out_tick(t0),
    .out_data(o0_d), .out_valid(o0_v), .level(o0_l), .overflow(o0_ovf),
    .underflow(o0_unf), .clear_flags(c0));

  // Reference: a frame queue of at most 8 entries; popped frames appear one edge after the pop.
  logic [31:0] q1[$], q0[$];
  logic [31:0] m1_prev, m1_out, m1_pd, m0_out, m0_pd;
  logic m1_ov, m1_pv, m1_ovf, m1_unf, m1_wr, m1_pop;
  logic m0_ov, m0_pv, m0_ovf, m0_unf, m0_pop;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q1.delete(); m1_prev = 0; m1_out = 0; m1_pd = 0; m1_ov = 0; m1_pv = 0; m1_ovf = 0; m1_unf = 0;
      q0.delete(); m0_out = 0; m0_pd = 0; m0_ov = 0; m0_pv = 0; m0_ovf = 0; m0_unf = 0;
    end else begin
      m1_wr = d1 != m1_prev;
      m1_prev = d1;
      m1_ov = m1_pv;
      if (m1_pv) m1_out = m1_pd;
      m1_pop = t1 && q1.size() != 0;
      m1_ovf = (m1_wr && q1.size() == 8 && !m1_pop) || (m1_ovf && !c1);
      m1_unf = (t1 && q1.size() == 0) || (m1_unf && !c1);
      m1_pv = m1_pop;
      if (m1_pop) m1_pd = q1.pop_front();
      if (m1_wr && q1.size() < 8) q1.push_back(d1);
      m0_ov = m0_pv;
      if (m0_pv) m0_out = m0_pd;
      m0_pop = t0 && q0.size() != 0;
      m0_ovf = (v0 && q0.size() == 8 && !m0_pop) || (m0_ovf && !c0);
      m0_unf = (t0 && q0.size() == 0) || (m0_unf && !c0);
      m0_pv = m0_pop;
      if (m0_pop) m0_pd = q0.pop_front();
      if (v0 && q0.size() < 8) q0.push_back(d0);
    end
  end

  task automatic test_reset;
    reset = 1;
    repeat (2) @(negedge clk);
    checks += 5;
    if (o1_d !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", o1_d); end
    if (o1_v !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", o1_v); end
    if (o1_l !== 4'd0) begin errors++; $display("FAIL reset_level: got %0d want 0", o1_l); end
    if (o1_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", o1_ovf); end
    if (o1_unf !== 1'b0) begin errors++; $display("FAIL reset_unf: got %b want 0", o1_unf); end
    reset = 0;
    @(negedge clk);
  endtask

  task automatic test_single;
    d1 = 32'h1111_2222;
    @(negedge clk);
    checks++;
    if (o1_l !== 4'd1) begin errors++; $display("FAIL single_level: got %0d want 1", o1_l); end
    t1 = 1;
    @(negedge clk);
    t1 = 0;
    checks += 2;
    if (o1_l !== 4'd0) begin errors++; $display("FAIL single_pop_level: got %0d want 0", o1_l); end
    if (o1_v !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", o1_v); end
    @(negedge clk);
    checks += 2;
    if (o1_d !== 32'h1111_2222) begin errors++; $display("FAIL single_data: got %h want 11112222", o1_d); end
    if (o1_v !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", o1_v); end
    @(negedge clk);
    checks++;
    if (o1_v !== 1'b0) begin errors++; $display("FAIL single_valid_pulse: got %b want 0", o1_v); end
  endtask

  task automatic test_overflow;
    logic [31:0] got[$];
    for (int i = 0; i < 10; i++) begin
      d1 = 32'hF000_0001 + i;
      @(negedge clk);
    end
    checks += 2;
    if (o1_l !== 4'd8) begin errors++; $display("FAIL ovf_level: got %0d want 8", o1_l); end
    if (o1_ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b want 1", o1_ovf); end
    t1 = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 7) t1 = 0;
      if (o1_v) got.push_back(o1_d);
    end
    checks += 3;
    if (got.size() != 8) begin errors++; $display("FAIL ovf_count: got %0d want 8", got.size()); end
    for (int k = 0; k < got.size() && k < 8; k++) begin
      checks++;
      if (got[k] !== 32'hF000_0001 + k) begin errors++; $display("FAIL ovf_order[%0d]: got %h want %h", k, got[k], 32'hF000_0001 + k); end
    end
    if (o1_l !== 4'd0) begin errors++; $display("FAIL ovf_drain_level: got %0d want 0", o1_l); end
    if (o1_unf !== 1'b0) begin errors++; $display("FAIL ovf_no_unf: got %b want 0", o1_unf); end
    c1 = 1;
    @(negedge clk);
    c1 = 0;
    checks++;
    if (o1_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b want 0", o1_ovf); end
  endtask

  task automatic test_underflow;
    d1 = 32'hAAAA_5555;
    @(negedge clk);
    t1 = 1;
    @(negedge clk);
    t1 = 0;
    @(negedge clk);
    checks++;
    if (o1_d !== 32'hAAAA_5555) begin errors++; $display("FAIL unf_setup: got %h want aaaa5555", o1_d); end
    @(negedge clk);
    t1 = 1;
    @(negedge clk);
    t1 = 0;
    checks += 2;
    if (o1_unf !== 1'b1) begin errors++; $display("FAIL unf_flag: got %b want 1", o1_unf); end
    if (o1_v !== 1'b0) begin errors++; $display("FAIL unf_valid0: got %b want 0", o1_v); end
    @(negedge clk);
    checks += 2;
    if (o1_v !== 1'b0) begin errors++; $display("FAIL unf_valid1: got %b want 0", o1_v); end
    if (o1_d !== 32'hAAAA_5555) begin errors++; $display("FAIL unf_hold: got %h want aaaa5555", o1_d); end
    c1 = 1;
    @(negedge clk);
    c1 = 0;
    checks++;
    if (o1_unf !== 1'b0) begin errors++; $display("FAIL unf_clear: got %b want 0", o1_unf); end
  endtask

  task automatic test_full_pop_write;
    logic [31:0] got[$];
    for (int i = 0; i < 8; i++) begin
      d1 = 32'hB000_0001 + i;
      @(negedge clk);
    end
    d1 = 32'hB000_0009;
    t1 = 1;
    @(negedge clk);
    t1 = 0;
    checks += 2;
    if (o1_l !== 4'd8) begin errors++; $display("FAIL fpw_level: got %0d want 8", o1_l); end
    if (o1_ovf !== 1'b0) begin errors++; $display("FAIL fpw_ovf: got %b want 0", o1_ovf); end
    @(negedge clk);
    checks += 2;
    if (o1_v !== 1'b1) begin errors++; $display("FAIL fpw_valid: got %b want 1", o1_v); end
    if (o1_d !== 32'hB000_0001) begin errors++; $display("FAIL fpw_oldest: got %h want b0000001", o1_d); end
    t1 = 1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i == 7) t1 = 0;
      if (o1_v) got.push_back(o1_d);
    end
    checks++;
    if (got.size() != 8) begin errors++; $display("FAIL fpw_count: got %0d want 8", got.size()); end
    for (int k = 0; k < got.size() && k < 8; k++) begin
      checks++;
      if (got[k] !== 32'hB000_0002 + k) begin errors++; $display("FAIL fpw_order[%0d]: got %h want %h", k, got[k], 32'hB000_0002 + k); end
    end
  endtask

  task automatic test_valid_mode;
    logic [5:0] pat;
    d0 = 32'h0100_0100;
    for (int i = 0; i < 3; i++) begin
      v0 = 1;
      @(negedge clk);
      v0 = 0;
      @(negedge clk);
    end
    checks++;
    if (o0_l !== 4'd3) begin errors++; $display("FAIL vm_level: got %0d want 3", o0_l); end
    d0 = 32'h1234_5678;
    @(negedge clk);
    d0 = 32'h0100_0100;
    checks++;
    if (o0_l !== 4'd3) begin errors++; $display("FAIL vm_no_change_write: got %0d want 3", o0_l); end
    pat = 0;
    t0 = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) t0 = 0;
      pat[i] = o0_v;
      if (o0_v) begin
        checks++;
        if (o0_d !== 32'h0100_0100) begin errors++; $display("FAIL vm_data[%0d]: got %h want 01000100", i, o0_d); end
      end
    end
    checks += 2;
    if (pat !== 6'b001110) begin errors++; $display("FAIL vm_valid_pattern: got %b want 001110", pat); end
    if (o0_l !== 4'd0) begin errors++; $display("FAIL vm_drain_level: got %0d want 0", o0_l); end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 5; i++) begin
      d1 = 32'hC000_0001 + i;
      @(negedge clk);
    end
    checks++;
    if (o1_l !== 4'd5) begin errors++; $display("FAIL rm_level5: got %0d want 5", o1_l); end
    t1 = 1;
    @(negedge clk);
    #2 reset = 1;
    #1;
    checks += 4;
    if (o1_d !== 32'h0) begin errors++; $display("FAIL rm_data: got %h want 0", o1_d); end
    if (o1_v !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b want 0", o1_v); end
    if (o1_l !== 4'd0) begin errors++; $display("FAIL rm_level: got %0d want 0", o1_l); end
    if (o1_unf !== 1'b0) begin errors++; $display("FAIL rm_unf: got %b want 0", o1_unf); end
    t1 = 0;
    d1 = 0;
    @(negedge clk);
    reset = 0;
    @(negedge clk);
    t1 = 1;
    @(negedge clk);
    t1 = 0;
    checks += 2;
    if (o1_unf !== 1'b1) begin errors++; $display("FAIL rm_after_unf: got %b want 1", o1_unf); end
    if (o1_v !== 1'b0) begin errors++; $display("FAIL rm_after_valid0: got %b want 0", o1_v); end
    @(negedge clk);
    checks++;
    if (o1_v !== 1'b0) begin errors++; $display("FAIL rm_after_valid1: got %b want 0", o1_v); end
  endtask

  task automatic test_random;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 1) == 1) d1 = $urandom;
      t1 = (i < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      c1 = $urandom_range(0, 19) == 0;
      d0 = $urandom;
      v0 = $urandom_range(0, 1) == 1;
      t0 = (i < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      c0 = $urandom_range(0, 19) == 0;
      @(negedge clk);
      checks += 10;
      if (o1_d !== m1_out) begin errors++; $display("FAIL rnd1_data@%0d: got %h want %h", i, o1_d, m1_out); end
      if (o1_v !== m1_ov) begin errors++; $display("FAIL rnd1_valid@%0d: got %b want %b", i, o1_v, m1_ov); end
      if (o1_l !== 4'(q1.size())) begin errors++; $display("FAIL rnd1_level@%0d: got %0d want %0d", i, o1_l, q1.size()); end
      if (o1_ovf !== m1_ovf) begin errors++; $display("FAIL rnd1_ovf@%0d: got %b want %b", i, o1_ovf, m1_ovf); end
      if (o1_unf !== m1_unf) begin errors++; $display("FAIL rnd1_unf@%0d: got %b want %b", i, o1_unf, m1_unf); end
      if (o0_d !== m0_out) begin errors++; $display("FAIL rnd0_data@%0d: got %h want %h", i, o0_d, m0_out); end
      if (o0_v !== m0_ov) begin errors++; $display("FAIL rnd0_valid@%0d: got %b want %b", i, o0_v, m0_ov); end
      if (o0_l !== 4'(q0.size())) begin errors++; $display("FAIL rnd0_level@%0d: got %0d want %0d", i, o0_l, q0.size()); end
      if (o0_ovf !== m0_ovf) begin errors++; $display("FAIL rnd0_ovf@%0d: got %b want %b", i, o0_ovf, m0_ovf); end
      if (o0_unf !== m0_unf) begin errors++; $display("FAIL rnd0_unf@%0d: got %b want %b", i, o0_unf, m0_unf); end
    end
    t1 = 0; c1 = 0; v0 = 0; t0 = 0; c0 = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_underflow();
    test_full_pop_write();
    test_valid_mode();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
